// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the rx framer and the FIFO it feeds.
package uart_pkg;

  // Sample ticks per bit period.
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_rx_state_t;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through byte FIFO. The head entry is read straight from storage.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int W          = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        push_i,
  input  logic [W-1:0]                push_data_i,
  input  logic                        pop_i,
  output logic [W-1:0]                head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Pop on empty is ignored; a full FIFO accepts a push only alongside a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: pin synchroniser, 16x oversampling with 3-sample majority vote,
// framing FSM and a byte FIFO presented over valid/ready.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        rx_serial,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int DIV_W = $clog2(DIV) + 1;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_rx_framer: CLK_HZ too low for BAUD, divider below 2");
    end
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_chk
      $error("uart_rx_framer: only 16x oversampling is supported");
    end
  endgenerate

  logic [1:0]     rst_sync_q;
  logic           rst_n_int;
  logic           rx_meta_q;
  logic           rxs_q;
  logic           rxs_prev_q;
  uart_rx_state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]     s_q, s_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     smp_q, smp_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_err_q, overrun_err_d;
  logic           tick;
  logic           vote;
  logic           vote_now;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;

  // Reset asserts immediately and releases two clocks after RST_N rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Two-flop pin synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_serial;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // FSM, tick divider, sample counter and error pulse registers.
  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= IDLE;
      div_q         <= '0;
      s_q           <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      smp_q         <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      s_q           <= s_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      smp_q         <= smp_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Next-state logic: counters run only inside a frame and restart at the start edge.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    s_d         = s_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    smp_d       = smp_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    vote_now    = 1'b0;
    tick        = (div_q == DIV_W'(DIV - 1));
    vote        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    if (state_q == START || state_q == DATA || state_q == STOP) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        s_d = s_q + 1'b1;
        if (s_q == 4'd7) smp_d[0] = rxs_q;
        if (s_q == 4'd8) smp_d[1] = rxs_q;
        vote_now = (s_q == 4'd9);
      end
    end

    case (state_q)
      IDLE: begin
        div_d = '0;
        s_d   = '0;
        if (rxs_prev_q && !rxs_q) state_d = START;
      end
      START: begin
        if (vote_now) begin
          if (!vote) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (vote_now) begin
          if (vote) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end
      end
      BRK: begin
        div_d = '0;
        s_d   = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    overrun_err_d = push && fifo_full && !rx_ready;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .W         (8)
  ) u_fifo (
    .CLK        (CLK),
    .RST_N      (rst_n_int),
    .push_i     (push),
    .push_data_i(shift_q),
    .pop_i      (rx_ready),
    .head_o     (rx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign rx_valid    = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
